fifo_run_tester: RTL

Parametrised successor to the single-FIFO run-request test kernel. It exercises an internal FIFO of configurable width and depth. On a run request it streams a configurable number of pattern words through the FIFO, in either fill-then-drain or concurrent mode, and self-checks every word read. It reports the error count and busy-cycle count, so the testbench no longer needs its own cycle counter. It sits under the top-level testbench or bring-up wrapper and uses the same `i_run_req` / `o_run_busy` handshake.

---
 rtl/fifo_test_pkg.sv | 28 ++
 rtl/fifo_run_tester_fifo.sv | 55 +++++
 rtl/fifo_run_tester.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fifo_test_pkg.sv
// Shared types and helpers for the FIFO run tester.
// Holds the FSM state enum, mode constants and a saturating increment.
package fifo_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_e;

  localparam int MODE_FILL = 0;
  localparam int MODE_CONC = 1;

  // Increment v, holding at the all-ones value of a w-bit field.
  // w must be between 1 and 63.
  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input int unsigned w
  );
    logic [63:0] m;
    m = {64{1'b1}} >> (64 - w);
    return (v == m) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/fifo_run_tester_fifo.sv
// Synchronous FIFO with registered read data.
// Ports: clock, reset, ce, push/wr_data, pop/rd_data, full, empty.
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty on wrap.
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [DATA_W-1:0] mem [DEPTH];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else if (ce) begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rd_data <= mem[rptr[AW-1:0]];
        rptr    <= rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && ce && push)
      mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (!reset && ce) begin
      assert (!(push && full));
      assert (!(pop && empty));
    end
  end

endmodule

// File: rtl/fifo_run_tester.sv
// Run-request FIFO test kernel: streams seed+k words through a FIFO.
// Ports: clock/reset/ce, run request, length/seed, inject, busy/done/counts.
module fifo_run_tester
  import fifo_test_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 16,
  parameter int MODE   = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ce,
  input  logic              i_run_req,
  input  logic [LEN_W-1:0]  i_length,
  input  logic [DATA_W-1:0] i_seed,
  input  logic              i_inject,
  output logic              o_run_busy,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_err_count,
  output logic [LEN_W-1:0]  o_cycles
);

  state_e            state;
  state_e            state_n;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  push_cnt;
  logic [LEN_W-1:0]  pop_cnt;
  logic [LEN_W-1:0]  err_cnt;
  logic [LEN_W-1:0]  cyc_cnt;
  logic [LEN_W-1:0]  occ;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] exp_q;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              chk_q;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              more;
  logic              start;

  assign occ   = push_cnt - pop_cnt;
  assign more  = (push_cnt != len);
  assign start = (state == S_IDLE) && i_run_req;

  assign wr_data = (seed + DATA_W'(push_cnt)) ^ DATA_W'(i_inject);

  always_comb begin
    state_n = state;
    push    = 1'b0;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_run_req) begin
          if (i_length == '0)
            state_n = S_DONE;
          else if (MODE == MODE_CONC)
            state_n = S_STREAM;
          else
            state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        push = 1'b1;
        // Leave on the push that fills the FIFO or ends the run.
        if ((push_cnt + LEN_W'(1) == len) ||
            (occ == LEN_W'(DEPTH - 1)))
          state_n = S_READ;
      end
      S_READ: begin
        pop = 1'b1;
        if (occ == LEN_W'(1))
          state_n = more ? S_WRITE : S_FLUSH;
      end
      S_STREAM: begin
        push = !full && more;
        pop  = !empty;
        if (pop && (pop_cnt + LEN_W'(1) == len))
          state_n = S_FLUSH;
      end
      S_FLUSH: state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      len      <= '0;
      seed     <= '0;
      push_cnt <= '0;
      pop_cnt  <= '0;
      err_cnt  <= '0;
      cyc_cnt  <= '0;
      exp_q    <= '0;
      chk_q    <= 1'b0;
    end else if (ce) begin
      state <= state_n;
      if (start) begin
        len      <= i_length;
        seed     <= i_seed;
        push_cnt <= '0;
        pop_cnt  <= '0;
        err_cnt  <= '0;
        cyc_cnt  <= '0;
        chk_q    <= 1'b0;
      end else begin
        if (push) push_cnt <= push_cnt + 1'b1;
        if (pop)  pop_cnt  <= pop_cnt + 1'b1;
        // Read data lands one cycle after the pop.
        chk_q <= pop;
        exp_q <= seed + DATA_W'(pop_cnt);
        if (chk_q && (rd_data != exp_q))
          err_cnt <= LEN_W'(sat_inc(64'(err_cnt), LEN_W));
        if (state != S_IDLE)
          cyc_cnt <= LEN_W'(sat_inc(64'(cyc_cnt), LEN_W));
      end
    end
  end

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty)
  );

  assign o_run_busy  = (state != S_IDLE);
  assign o_done      = (state == S_DONE);
  assign o_err_count = err_cnt;
  assign o_cycles    = cyc_cnt;

endmodule
